// File: rtl/uart_frame_loader.sv
// UART receive framing stage: parses sync/addr/len/payload/checksum frames and writes packed words to BRAM.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_frame_loader #(
    parameter int unsigned N              = 256,
    parameter int unsigned ABITS          = 8,
    parameter int unsigned DBITS          = N,
    parameter int unsigned TIMEOUT_CYCLES = 30000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             start,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned BYTES = N / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [7:0]  SYNC  = 8'hA5;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] LEN     = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] CSUM    = 3'd4;

    // Parameter sanity, evaluated at elaboration
    if ((N == 0) || (N % 8 != 0)) begin : g_bad_n
        $error("uart_frame_loader: N must be a nonzero multiple of 8");
    end
    if (DBITS != N) begin : g_bad_dbits
        $error("uart_frame_loader: DBITS must equal N");
    end
    if ((ABITS == 0) || (ABITS > 8)) begin : g_bad_abits
        $error("uart_frame_loader: ABITS must be 1..8");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("uart_frame_loader: TIMEOUT_CYCLES must be nonzero");
    end

    logic [2:0]       state_q,    state_d;
    logic [ABITS-1:0] base_q,     base_d;
    logic [7:0]       len_q,      len_d;
    logic [7:0]       word_idx_q, word_idx_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [N-1:0]     shift_q,    shift_d;
    logic [7:0]       csum_q,     csum_d;
    logic             wr_en_q,    wr_en_d;
    logic [ABITS-1:0] wr_addr_q,  wr_addr_d;
    logic [DBITS-1:0] wr_data_q,  wr_data_d;
    logic             start_q,    start_d;
    logic             fe_q,       fe_d;
    logic             busy_q,     busy_d;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = 1'b0;
        fe_d       = 1'b0;

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte == SYNC) begin
                        state_d    = ADDR;
                        csum_d     = 8'h00;
                        byte_cnt_d = '0;
                        word_idx_d = 8'h00;
                    end
                end
                ADDR: begin
                    base_d  = rx_byte[ABITS-1:0];
                    csum_d  = csum_q ^ rx_byte;
                    state_d = LEN;
                end
                LEN: begin
                    len_d   = rx_byte;
                    csum_d  = csum_q ^ rx_byte;
                    state_d = (rx_byte == 8'h00) ? CSUM : PAYLOAD;
                end
                PAYLOAD: begin
                    csum_d  = csum_q ^ rx_byte;
                    shift_d = N'({shift_q, rx_byte});
                    if (byte_cnt_q == BCW'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = base_q + ABITS'(word_idx_q);
                        wr_data_d  = DBITS'(shift_d);
                        word_idx_d = word_idx_q + 8'd1;
                        if (word_idx_q == len_q - 8'd1) begin
                            state_d = CSUM;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
                CSUM: begin
                    if (rx_byte == csum_q) begin
                        start_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef LOADER_TIMEOUT_EN
        to_cnt_d = (rx_valid || (state_q == IDLE)) ? '0 : to_cnt_q + TOW'(1);
        if ((state_q != IDLE) && !rx_valid && (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1))) begin
            state_d    = IDLE;
            fe_d       = 1'b1;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
        end
`endif

        // Derived from next state so busy drops together with start/frame_error
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= 8'h00;
            word_idx_q <= 8'h00;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= 8'h00;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= 1'b0;
            fe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            fe_q       <= fe_d;
            busy_q     <= busy_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign start       = start_q;
    assign frame_error = fe_q;
    assign busy        = busy_q;

endmodule
